// File: rtl/warp_scheduler.sv
// warp_scheduler: round-robin SIMT warp scheduler holding a PC and lane mask per warp.
// Optional feature: define WARP_SCHEDULER_DIVERGENCE_EN to build the per-warp divergence
// stack (push on divergent branch, pop on ret). Without it, divergent branches follow the
// lowest-indexed active lane and ret always retires the warp.
module warp_scheduler #(
  parameter int NUM_WARPS        = 2,
  parameter int THREADS_PER_WARP = 4,
  parameter int PC_BITS          = 8,
  parameter int STACK_DEPTH      = 4,
  localparam int WW   = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  localparam int TC_W = $clog2(NUM_WARPS * THREADS_PER_WARP) + 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [TC_W-1:0]             thread_count,
  output logic                        fetch_valid,
  output logic [PC_BITS-1:0]          fetch_pc,
  input  logic                        fetch_ready,
  input  logic                        decoded_mem,
  input  logic                        decoded_ret,
  input  logic                        decoded_branch,
  input  logic [PC_BITS-1:0]          decoded_target,
  input  logic [THREADS_PER_WARP-1:0] lane_taken,
  input  logic                        lsu_busy,
  output logic [WW-1:0]               issue_warp,
  output logic [THREADS_PER_WARP-1:0] active_mask,
  output logic [2:0]                  core_state,
  output logic                        stack_overflow,
  output logic                        done
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_REQUEST = 3'd3,
    S_WAIT    = 3'd4,
    S_EXECUTE = 3'd5,
    S_UPDATE  = 3'd6,
    S_DONE    = 3'd7
  } state_t;

  state_t                      state_q, state_d;
  logic [PC_BITS-1:0]          pc_q   [NUM_WARPS];
  logic [THREADS_PER_WARP-1:0] mask_q [NUM_WARPS];
  logic [NUM_WARPS-1:0]        retired_q;
  logic [WW-1:0]               warp_q;
  logic [THREADS_PER_WARP-1:0] taken_q;
  logic                        ovf_q;

  // launch-time decode of thread_count into per-warp masks
  logic [THREADS_PER_WARP-1:0] launch_mask [NUM_WARPS];
  logic [NUM_WARPS-1:0]        launch_retired;
  logic [WW-1:0]               launch_warp;
  logic                        launch_found;

  // UPDATE-stage results for the issued warp
  logic [PC_BITS-1:0]          cur_pc, pc_inc, upd_pc;
  logic [THREADS_PER_WARP-1:0] cur_mask, low_lane, upd_mask;
  logic                        follow_taken, upd_retire, ovf_set;
  logic [NUM_WARPS-1:0]        retired_nxt;
  logic [WW-1:0]               nxt_warp, cand;
  logic                        any_live;

`ifdef WARP_SCHEDULER_DIVERGENCE_EN
  localparam int SP_W = $clog2(STACK_DEPTH + 1);
  localparam int SI_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  logic [SP_W-1:0]             sp_q      [NUM_WARPS];
  logic [PC_BITS-1:0]          stk_pc_q  [NUM_WARPS][STACK_DEPTH];
  logic [THREADS_PER_WARP-1:0] stk_msk_q [NUM_WARPS][STACK_DEPTH];
  logic [SI_W-1:0]             top_idx, push_idx;
  logic                        do_push, do_pop;
`endif

  assign cur_pc   = pc_q[warp_q];
  assign cur_mask = mask_q[warp_q];
  assign pc_inc   = cur_pc + PC_BITS'(1);
  // isolate the lowest set bit of the active mask
  assign low_lane     = cur_mask & (~cur_mask + THREADS_PER_WARP'(1));
  assign follow_taken = |(taken_q & low_lane);

  assign core_state     = state_q;
  assign fetch_valid    = (state_q == S_FETCH);
  assign fetch_pc       = pc_q[warp_q];
  assign issue_warp     = warp_q;
  assign active_mask    = ((state_q == S_IDLE) || (state_q == S_DONE)) ? '0 : mask_q[warp_q];
  assign done           = (state_q == S_DONE);
  assign stack_overflow = ovf_q;

  // Build launch masks: lane l of warp w is live iff its global index is below thread_count
  always_comb begin
    launch_warp  = '0;
    launch_found = 1'b0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      launch_mask[w] = '0;
      for (int l = 0; l < THREADS_PER_WARP; l++)
        launch_mask[w][l] = ((w * THREADS_PER_WARP + l) < int'(thread_count));
      launch_retired[w] = ~|launch_mask[w];
      if (!launch_found && !launch_retired[w]) begin
        launch_warp  = WW'(w);
        launch_found = 1'b1;
      end
    end
  end

`ifdef WARP_SCHEDULER_DIVERGENCE_EN
  assign top_idx  = SI_W'(sp_q[warp_q] - SP_W'(1));
  assign push_idx = SI_W'(sp_q[warp_q]);
`endif

  // Resolve the issued warp's next PC/mask/retire status and the round-robin successor
  always_comb begin
    upd_pc     = pc_inc;
    upd_mask   = cur_mask;
    upd_retire = 1'b0;
    ovf_set    = 1'b0;
`ifdef WARP_SCHEDULER_DIVERGENCE_EN
    do_push    = 1'b0;
    do_pop     = 1'b0;
`endif
    if (decoded_ret) begin
`ifdef WARP_SCHEDULER_DIVERGENCE_EN
      if (sp_q[warp_q] != '0) begin
        do_pop   = 1'b1;
        upd_pc   = stk_pc_q[warp_q][top_idx];
        upd_mask = stk_msk_q[warp_q][top_idx];
      end else
`endif
        upd_retire = 1'b1;
    end else if (decoded_branch) begin
      if (taken_q == cur_mask) begin
        upd_pc = decoded_target;
      end else if (taken_q != '0) begin
`ifdef WARP_SCHEDULER_DIVERGENCE_EN
        if (sp_q[warp_q] != SP_W'(STACK_DEPTH)) begin
          do_push  = 1'b1;
          upd_mask = taken_q;
          upd_pc   = decoded_target;
        end else begin
          ovf_set = 1'b1;
          if (follow_taken) upd_pc = decoded_target;
        end
`else
        if (follow_taken) upd_pc = decoded_target;
`endif
      end
    end

    retired_nxt = retired_q;
    if (upd_retire) retired_nxt[warp_q] = 1'b1;

    nxt_warp = warp_q;
    any_live = 1'b0;
    cand     = '0;
    for (int k = 1; k <= NUM_WARPS; k++) begin
      cand = WW'((int'(warp_q) + k) % NUM_WARPS);
      if (!any_live && !retired_nxt[cand]) begin
        nxt_warp = cand;
        any_live = 1'b1;
      end
    end
  end

  // Next-state logic of the per-instruction core FSM
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = (thread_count == '0) ? S_DONE : S_FETCH;
      S_FETCH:   if (fetch_ready) state_d = S_DECODE;
      S_DECODE:  state_d = S_REQUEST;
      S_REQUEST: state_d = S_WAIT;
      S_WAIT:    if (!decoded_mem || !lsu_busy) state_d = S_EXECUTE;
      S_EXECUTE: state_d = S_UPDATE;
      S_UPDATE:  state_d = any_live ? S_FETCH : S_DONE;
      S_DONE:    state_d = S_DONE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Control state: FSM, per-warp PC/mask/retire, issue pointer, overflow flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      warp_q    <= '0;
      retired_q <= '0;
      ovf_q     <= 1'b0;
      for (int w = 0; w < NUM_WARPS; w++) begin
        pc_q[w]   <= '0;
        mask_q[w] <= '0;
`ifdef WARP_SCHEDULER_DIVERGENCE_EN
        sp_q[w]   <= '0;
`endif
      end
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && start) begin
        retired_q <= launch_retired;
        warp_q    <= launch_warp;
        for (int w = 0; w < NUM_WARPS; w++) begin
          pc_q[w]   <= '0;
          mask_q[w] <= launch_mask[w];
`ifdef WARP_SCHEDULER_DIVERGENCE_EN
          sp_q[w]   <= '0;
`endif
        end
      end else if (state_q == S_UPDATE) begin
        pc_q[warp_q]   <= upd_pc;
        mask_q[warp_q] <= upd_mask;
        retired_q      <= retired_nxt;
        warp_q         <= nxt_warp;
        if (ovf_set) ovf_q <= 1'b1;
`ifdef WARP_SCHEDULER_DIVERGENCE_EN
        if (do_push)     sp_q[warp_q] <= sp_q[warp_q] + SP_W'(1);
        else if (do_pop) sp_q[warp_q] <= sp_q[warp_q] - SP_W'(1);
`endif
      end
    end
  end

  // Capture the branch outcome of the active lanes at the end of EXECUTE
  always_ff @(posedge clk) begin
    if (state_q == S_EXECUTE) taken_q <= lane_taken & mask_q[warp_q];
  end

`ifdef WARP_SCHEDULER_DIVERGENCE_EN
  // Divergence stack storage: reconvergence PC and the lanes left behind
  always_ff @(posedge clk) begin
    if (state_q == S_UPDATE && do_push) begin
      stk_pc_q[warp_q][push_idx]  <= pc_inc;
      stk_msk_q[warp_q][push_idx] <= cur_mask & ~taken_q;
    end
  end
`endif

endmodule

// File: doc/warp_scheduler.md
WARP_SCHEDULER -- requirements
Module: warp_scheduler

Interface
REQ-001 Parameter NUM_WARPS, default 2, number of warps resident in the core.
REQ-002 Parameter THREADS_PER_WARP, default 4, SIMT lanes per warp.
REQ-003 Parameter PC_BITS, default 8, program counter width.
REQ-004 Parameter STACK_DEPTH, default 4, divergence-stack entries per warp.
REQ-005 clk  input  1  rising-edge clock; the block has this one clock only.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  launch pulse, sampled in IDLE.
REQ-008 thread_count  input  $clog2(NUM_WARPS*THREADS_PER_WARP)+1  total live threads in the block.
REQ-009 fetch_valid  output  1  program fetch request.
REQ-010 fetch_pc  output  PC_BITS  PC of the issued warp.
REQ-011 fetch_ready  input  1  instruction returned; qualifies fetch_valid.
REQ-012 decoded_mem, decoded_ret, decoded_branch  input  1 each  decoder flags, valid from DECODE onward.
REQ-013 decoded_target  input  PC_BITS  branch target.
REQ-014 lane_taken  input  THREADS_PER_WARP  per-lane NZP-match result, valid in EXECUTE.
REQ-015 lsu_busy  input  1  OR of all lane LSUs waiting.
REQ-016 issue_warp  output  max(1,$clog2(NUM_WARPS))  warp currently issued.
REQ-017 active_mask  output  THREADS_PER_WARP  lane enables of the issued warp.
REQ-018 core_state  output  3  IDLE=0 FETCH=1 DECODE=2 REQUEST=3 WAIT=4 EXECUTE=5 UPDATE=6 DONE=7.
REQ-019 stack_overflow  output  1  sticky divergence-stack overflow flag.
REQ-020 done  output  1  all warps retired.

Function
REQ-021 IDLE->FETCH on start: warp w mask bit l SHALL be set iff w*THREADS_PER_WARP+l < thread_count; all PCs 0; warps with empty mask are marked retired; issue_warp = lowest live warp; thread_count 0 goes directly to DONE.
REQ-022 FETCH: fetch_valid=1 with fetch_pc = PC of issue_warp, held until fetch_ready; the cycle after fetch_ready it SHALL drop and the state SHALL go to DECODE.
REQ-023 DECODE->REQUEST->WAIT unconditionally, one cycle each.
REQ-024 WAIT->EXECUTE when decoded_mem=0 or lsu_busy=0; otherwise WAIT is held.
REQ-025 EXECUTE->UPDATE after one cycle; lane_taken SHALL be sampled ANDed with active_mask (T).
REQ-026 UPDATE, non-branch, non-ret: PC <= PC+1, wrapping modulo 2^PC_BITS.
REQ-027 UPDATE, branch, T equals active_mask: PC <= decoded_target; T=0: PC <= PC+1.
REQ-028 UPDATE, ret, stack empty: warp retired; ret, stack non-empty: pop top entry into PC and mask.
REQ-029 UPDATE selects next warp round-robin: first non-retired warp after issue_warp, wrapping; may reselect the same warp; none left -> DONE, else FETCH.
REQ-030 DONE: done=1, held until reset; start ignored.
REQ-031 active_mask SHALL equal the issued warp's mask in every state except IDLE and DONE, where it is 0.

Reset
REQ-032 reset low SHALL immediately force core_state=IDLE, fetch_valid=0, fetch_pc=0, issue_warp=0, active_mask=0, done=0, stack_overflow=0, all PCs/masks/stack pointers 0, in any state including mid-fetch or WAIT.

Configuration
REQ-033 Macro WARP_SCHEDULER_DIVERGENCE_EN defined: branch with 0 != T != active_mask SHALL push {PC+1, active_mask & ~T}, set mask <= T, PC <= decoded_target.
REQ-034 Divergent branch with stack full (macro defined): no push; stack_overflow <= 1; whole warp follows the lowest-indexed active lane.
REQ-035 Macro undefined: no stack is built, stack_overflow is tied 0, divergent branches follow the lowest-indexed active lane's outcome, and ret always retires the warp.

Verification
REQ-036 thread_count=6, defaults -> warp0 mask 1111, warp1 mask 0011; issue order 0,1,0,1 on straight-line code.
REQ-037 fetch_ready delayed 3 cycles -> fetch_valid held 3 cycles with fetch_pc stable, then DECODE.
REQ-038 decoded_mem=1, lsu_busy high 5 cycles -> WAIT held 5 cycles, EXECUTE on the cycle after lsu_busy falls.
REQ-039 Macro defined, PC=4, branch target 10, lane_taken=0101, mask 1111 -> mask 0101, PC 10; at ret, pop to mask 1010, PC 5; second ret retires warp.
REQ-040 STACK_DEPTH=1, two nested divergent branches -> second sets stack_overflow=1 and follows lane 0.
REQ-041 reset asserted during WAIT -> all outputs at reset values the same cycle; new start relaunches from PC 0.
